// File: rtl/mont_loader_pkg.sv
// Shared types and sizes for the Montgomery operand loader.
package mont_loader_pkg;

  localparam int WORDS_PER_OP = 8;
  localparam int WORD_W       = 64;
  localparam int OP_W         = 512;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  function automatic logic [WORD_W-1:0] word_sel(input logic [OP_W-1:0] op, input logic [2:0] idx);
    return op[{idx, 6'd0} +: WORD_W];
  endfunction

endpackage

// File: rtl/mont_word_shifter.sv
// 512-bit operand register filled one 64-bit word at a time by word index.
module mont_word_shifter
  import mont_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [2:0]        wr_idx_i,
  input  logic [WORD_W-1:0] wr_data_i,
  output logic [OP_W-1:0]   data_o
);

  logic [OP_W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= {OP_W{1'b0}};
    end else if (wr_en_i) begin
      data_q[{wr_idx_i, 6'd0} +: WORD_W] <= wr_data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/mont_loader.sv
// Streams A/B/M operands into a 512-bit multiplier, waits for its result
// under a watchdog, then streams the result back out LSW first.
module mont_loader
  import mont_loader_pkg::*;
#(
  parameter int WATCHDOG = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic              cmd_keep_m,
  output logic              cmd_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [OP_W-1:0]   mm_a,
  output logic [OP_W-1:0]   mm_b,
  output logic [OP_W-1:0]   mm_m,
  output logic              mm_start,
  input  logic [OP_W-1:0]   mm_result,
  input  logic              mm_done,
  output logic              err_timeout
);

  localparam int              WD_W    = $clog2(WATCHDOG + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG - 1);
  localparam logic [2:0]      J_LAST  = 3'(WORDS_PER_OP - 1);

  state_e            state_q;
  logic              keep_q;
  logic              m_loaded_q;
  logic [4:0]        cnt_q;
  logic [2:0]        j_q;
  logic [WD_W-1:0]   wd_q;
  logic [OP_W-1:0]   result_q;
  logic              cmd_ready_q;
  logic              in_ready_q;
  logic              mm_start_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              err_timeout_q;
  logic [WORD_W-1:0] out_data_q;

  logic       ld_s;
  logic [4:0] last_idx_s;

  // With a stored modulus the job skips the M words entirely.
  assign last_idx_s = (keep_q && m_loaded_q) ? 5'd15 : 5'd23;
  assign ld_s       = (state_q == ST_LOAD) && in_valid && in_ready_q;

  mont_word_shifter u_a (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (ld_s && (cnt_q[4:3] == 2'd0)),
    .wr_idx_i  (cnt_q[2:0]),
    .wr_data_i (in_data),
    .data_o    (mm_a)
  );

  mont_word_shifter u_b (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (ld_s && (cnt_q[4:3] == 2'd1)),
    .wr_idx_i  (cnt_q[2:0]),
    .wr_data_i (in_data),
    .data_o    (mm_b)
  );

  mont_word_shifter u_m (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (ld_s && (cnt_q[4:3] == 2'd2)),
    .wr_idx_i  (cnt_q[2:0]),
    .wr_data_i (in_data),
    .data_o    (mm_m)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      keep_q        <= 1'b0;
      m_loaded_q    <= 1'b0;
      cnt_q         <= 5'd0;
      j_q           <= 3'd0;
      wd_q          <= {WD_W{1'b0}};
      result_q      <= {OP_W{1'b0}};
      cmd_ready_q   <= 1'b1;
      in_ready_q    <= 1'b0;
      mm_start_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      out_data_q    <= {WORD_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            keep_q        <= cmd_keep_m;
            cnt_q         <= 5'd0;
            err_timeout_q <= 1'b0;
            cmd_ready_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            state_q       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid && in_ready_q) begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              m_loaded_q <= 1'b1;
            end
            if (cnt_q == last_idx_s) begin
              in_ready_q <= 1'b0;
              mm_start_q <= 1'b1;
              state_q    <= ST_START;
            end
          end
        end
        ST_START: begin
          mm_start_q <= 1'b0;
          wd_q       <= {WD_W{1'b0}};
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mm_done) begin
            result_q    <= mm_result;
            out_data_q  <= mm_result[WORD_W-1:0];
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            j_q         <= 3'd0;
            state_q     <= ST_DRAIN;
          end else if (wd_q == WD_LAST) begin
            err_timeout_q <= 1'b1;
            cmd_ready_q   <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (j_q == J_LAST) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              j_q        <= j_q + 3'd1;
              out_data_q <= word_sel(result_q, j_q + 3'd1);
              out_last_q <= (j_q == (J_LAST - 3'd1));
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          in_ready_q  <= 1'b0;
          mm_start_q  <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign in_ready    = in_ready_q;
  assign mm_start    = mm_start_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_data    = out_data_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mont_loader.sv
// Directed bench for mont_loader with an XOR multiplier stub and a result-word scoreboard.
module tb_mont_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_keep_m, cmd_ready;
  logic [63:0]  in_data;
  logic         in_valid, in_ready;
  logic [63:0]  out_data;
  logic         out_valid, out_last, out_ready;
  logic [511:0] mm_a, mm_b, mm_m, mm_result;
  logic         mm_start, mm_done;
  logic         err_timeout;

  int vec_cnt = 0;
  int err_cnt = 0;
  int start_cnt = 0;
  int stub_cnt;
  logic stub_en;
  logic [63:0] sb_q[$];

  mont_loader #(.WATCHDOG(20)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_keep_m(cmd_keep_m), .cmd_ready(cmd_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m), .mm_start(mm_start),
    .mm_result(mm_result), .mm_done(mm_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Multiplier stub: one-cycle done, six cycles after the start pulse, result = a ^ b.
  always @(posedge clk) begin
    if (reset) begin
      mm_done   <= 1'b0;
      mm_result <= '0;
      stub_cnt  <= 0;
    end else begin
      mm_done <= 1'b0;
      if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          mm_done   <= 1'b1;
          mm_result <= mm_a ^ mm_b;
        end
      end else if (mm_start && stub_en) begin
        stub_cnt <= 6;
      end
    end
    if (mm_start) start_cnt <= start_cnt + 1;
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    vec_cnt++;
    assert (obs == exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Issue a command at a negedge; returns at the negedge after acceptance.
  task automatic send_cmd(input logic keep);
    checkn("cmd_ready_idle", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_keep_m = keep;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    checkn("err_clear_on_cmd", int'(err_timeout), 0);
    checkn("in_ready_load", int'(in_ready), 1);
  endtask

  // Feed A, B, M words while the DUT accepts; returns at the negedge after the last word.
  task automatic load_words(input logic [511:0] a, input logic [511:0] b,
                            input logic [511:0] m, output int n);
    logic [63:0] w;
    int guard;
    n = 0; guard = 0;
    while (in_ready && guard < 40) begin
      if (n < 8)       w = a[n*64 +: 64];
      else if (n < 16) w = b[(n-8)*64 +: 64];
      else if (n < 24) w = m[(n-16)*64 +: 64];
      else             w = 64'd0;
      in_valid = 1'b1; in_data = w;
      @(posedge clk); n++;
      @(negedge clk); guard++;
    end
    in_valid = 1'b0;
  endtask

  // Compare result words against the scoreboard as handshakes occur.
  task automatic drain(input bit toggle);
    int guard = 0;
    int phase = 0;
    while (sb_q.size() > 0 && guard < 200) begin
      out_ready = toggle ? ((phase % 2) == 0) : 1'b1;
      phase++;
      if (out_valid) begin
        checkw("out_data", {448'd0, out_data}, {448'd0, sb_q[0]});
        checkn("out_last", int'(out_last), int'(sb_q.size() == 1));
        if (out_ready) void'(sb_q.pop_front());
      end
      @(posedge clk); @(negedge clk);
      guard++;
    end
    out_ready = 1'b1;
    checkn("drain_words_left", sb_q.size(), 0);
    checkn("out_valid_after", int'(out_valid), 0);
    checkn("cmd_ready_after", int'(cmd_ready), 1);
  endtask

  task automatic run_job(input logic keep, input logic [511:0] a, input logic [511:0] b,
                         input logic [511:0] m, input logic [511:0] m_exp,
                         input int n_exp, input bit toggle);
    int n;
    int starts;
    logic [511:0] r;
    send_cmd(keep);
    starts = start_cnt;
    load_words(a, b, m, n);
    checkn("words_accepted", n, n_exp);
    checkn("mm_start_pulse", int'(mm_start), 1);
    checkw("mm_a", mm_a, a);
    checkw("mm_b", mm_b, b);
    checkw("mm_m", mm_m, m_exp);
    r = a ^ b;
    for (int k = 0; k < 8; k++) sb_q.push_back(r[k*64 +: 64]);
    @(negedge clk);
    checkn("mm_start_one_cycle", int'(mm_start), 0);
    drain(toggle);
    checkn("start_count", start_cnt - starts, 1);
    checkw("mm_m_held", mm_m, m_exp);
  endtask

  initial begin
    logic [511:0] a, b, m, m_keep;
    int n, cyc;
    bit seen_valid;

    reset = 1'b1; cmd_valid = 1'b0; cmd_keep_m = 1'b0; in_valid = 1'b0;
    in_data = 64'd0; out_ready = 1'b1; stub_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // Reset state
    checkn("rst_cmd_ready", int'(cmd_ready), 1);
    checkn("rst_in_ready", int'(in_ready), 0);
    checkn("rst_mm_start", int'(mm_start), 0);
    checkn("rst_out_valid", int'(out_valid), 0);
    checkn("rst_out_last", int'(out_last), 0);
    checkn("rst_err", int'(err_timeout), 0);
    checkw("rst_mm_a", mm_a, '0);
    checkw("rst_mm_m", mm_m, '0);
    checkw("rst_out_data", {448'd0, out_data}, '0);

    // Basic job, full load
    run_job(1'b0, 512'h1, 512'h3, 512'hF, 512'hF, 24, 1'b0);

    // Reuse stored modulus: only A and B are taken
    a = rnd512(); b = rnd512(); m = rnd512();
    run_job(1'b1, a, b, m, 512'hF, 16, 1'b0);

    // Backpressured drain with new modulus
    a = rnd512(); b = rnd512(); m = rnd512();
    run_job(1'b0, a, b, m, m, 24, 1'b1);
    m_keep = m;

    // Watchdog abort: stub stays silent
    stub_en = 1'b0;
    a = rnd512(); b = rnd512();
    send_cmd(1'b1);
    load_words(a, b, a, n);
    checkn("wd_words", n, 16);
    checkn("wd_mm_start", int'(mm_start), 1);
    checkw("wd_mm_m_kept", mm_m, m_keep);
    cyc = 0; seen_valid = 1'b0;
    while (cyc < 100) begin
      @(negedge clk); cyc++;
      if (out_valid) seen_valid = 1'b1;
      if (err_timeout) break;
    end
    checkn("wd_cycles", cyc, 21);
    checkn("wd_err", int'(err_timeout), 1);
    checkn("wd_cmd_ready", int'(cmd_ready), 1);
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    checkn("wd_no_output", int'(seen_valid), 0);
    checkn("wd_err_sticky", int'(err_timeout), 1);
    stub_en = 1'b1;

    // Reset during LOAD at the 10th word
    a = rnd512(); b = rnd512(); m = rnd512();
    send_cmd(1'b0);
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1; in_data = (k < 8) ? a[k*64 +: 64] : b[(k-8)*64 +: 64];
      @(posedge clk); @(negedge clk);
    end
    in_data = b[64 +: 64]; reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    checkn("mid_rst_cmd_ready", int'(cmd_ready), 1);
    checkn("mid_rst_in_ready", int'(in_ready), 0);
    checkn("mid_rst_err", int'(err_timeout), 0);
    checkw("mid_rst_mm_a", mm_a, '0);
    checkw("mid_rst_mm_b", mm_b, '0);
    checkw("mid_rst_mm_m", mm_m, '0);

    // keep=1 with no stored modulus must load all three operands
    run_job(1'b1, a, b, m, m, 24, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mont_loader.md
MONT_LOADER -- requirements
Module: mont_loader

Interface
REQ-001 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have cmd_valid  input  1  job request; cmd_keep_m  input  1  reuse stored modulus; cmd_ready  output  1  high only in IDLE.
REQ-004 SHALL have in_data  input  64  operand word; in_valid  input  1; in_ready  output  1  high only in LOAD.
REQ-005 SHALL have out_data  output  64  result word; out_valid  output  1; out_last  output  1  marks word 7; out_ready  input  1.
REQ-006 SHALL have mm_a, mm_b, mm_m  output  512 each  operands to the multiplier; mm_start  output  1; mm_result  input  512; mm_done  input  1.
REQ-007 SHALL have err_timeout  output  1  sticky watchdog flag, cleared by reset or by the next accepted command.
REQ-008 SHALL have parameter WATCHDOG, default 4095, meaning max WAIT cycles before abort.

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, START, WAIT, DRAIN.
REQ-010 IDLE: on cmd_valid&cmd_ready, latch keep flag, clear word counter, go LOAD.
REQ-011 LOAD SHALL accept one 64-bit word per in_valid&in_ready cycle, order A[0..7], B[0..7], M[0..7]; word k lands in bits [64k+63:64k].
REQ-012 LOAD SHALL accept 16 words when keep flag=1 and m_loaded=1, otherwise 24 words; keep=1 with m_loaded=0 SHALL load M.
REQ-013 After the last LOAD word is accepted at edge t, mm_start SHALL be 1 for exactly the cycle after t (state START), then WAIT.
REQ-014 mm_a, mm_b, mm_m SHALL be direct register outputs, unchanged from START entry until DRAIN exit.
REQ-015 WAIT: on mm_done=1, capture mm_result into result register at that edge and go DRAIN; mm_done outside WAIT SHALL be ignored.
REQ-016 WAIT: watchdog counter SHALL count from 0; when it reaches WATCHDOG without mm_done, set err_timeout and go IDLE, no output words.
REQ-017 DRAIN: out_valid=1, out_data=result word j (j=0..7, LSW first), out_last=(j==7); j advances only on out_valid&out_ready.
REQ-018 out_ready=0 SHALL hold out_data and out_valid stable (no drop, no repeat).
REQ-019 After word 7 handshake, FSM SHALL return to IDLE; cmd_ready=1 the following cycle.
REQ-020 in_valid outside LOAD and cmd_valid outside IDLE SHALL be ignored with no state change.
REQ-021 m_loaded SHALL set when the 8th M word is accepted and stay set until reset.
REQ-022 Word counter 5 bits, result index 3 bits; neither SHALL wrap within a job.

Reset
REQ-023 Reset SHALL force IDLE, counters=0, m_loaded=0, err_timeout=0, mm_start=0, out_valid=0, out_last=0, cmd_ready=1 next cycle, in_ready=0.
REQ-024 Operand and result registers SHALL reset to 0; mm_a/mm_b/mm_m/out_data read 0 after reset.
REQ-025 Reset asserted mid-LOAD, WAIT or DRAIN SHALL abort the job; partial data SHALL not be reused.

Structure
REQ-026 Shared package SHALL hold state encoding, WORDS_PER_OP=8, WORD_W=64, OP_W=512.
REQ-027 One sub-module is natural: mont_word_shifter (512-bit register with 64-bit word write by index), instantiated for A, B, M.
REQ-028 Design SHALL be a single clock domain with no combinational path from mm_done to mm_start.

Verification (bench uses multiplier stub: done 1 cycle, 6 cycles after start, result = a XOR b)
REQ-029 A=0x1, B=0x3, M=0xF, keep=0, out_ready=1 -> one mm_start pulse; out words 0x2,0,0,0,0,0,0,0; out_last on 8th.
REQ-030 Second job keep=1 after REQ-029 -> exactly 16 words accepted, mm_m still 0xF.
REQ-031 keep=1 directly after reset -> 24 words accepted.
REQ-032 out_ready toggled 1/0 each cycle during DRAIN -> 8 distinct words, order preserved, data stable when stalled.
REQ-033 Stub never asserts done, WATCHDOG=20 -> err_timeout=1 at WAIT cycle 20, IDLE, out_valid never 1.
REQ-034 Reset asserted at 10th LOAD word -> IDLE, mm_* = 0, m_loaded=0, next job requires 24 words.
